load_stage: RTL and testbench

Input (absorb-side) stage of the SHAKE pipeline. It accepts w-bit message words from the external source over a valid/ready handshake and packs them into a rate-wide input buffer. It applies SHAKE padding (0x1F domain/pad byte, 0x80 final bit) and hands each completed block to the permutation stage with a one-cycle write strobe, gated by the downstream availability flag.

---
 rtl/keccak_pkg.sv | 39 +++
 rtl/load_stage_if.sv | 34 +++
 rtl/load_datapath.sv | 98 +++++++++
 rtl/load_fsm.sv | 87 ++++++++
 rtl/load_stage.sv | 55 +++++
 tb/tb_load_stage.sv | 242 ++++++++++++++++++++++++
 6 files changed

// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants and types for the SHAKE absorb pipeline.
//   w               lane/word width
//   RATE_SHAKE128   input buffer width (widest rate)
//   RATE_SHAKE256   SHAKE256 rate in bits
//   MODE_*          operation mode encodings
//   RATE_WORDS_*    rate expressed in w-bit words
//   PAD_*           padding bytes (domain/pad start, final bit)
//   load_state_t    load_fsm state encoding
package keccak_pkg;

    localparam int w             = 64;
    localparam int RATE_SHAKE128 = 1344;
    localparam int RATE_SHAKE256 = 1088;

    localparam logic [1:0] MODE_SHAKE128 = 2'b00;
    localparam logic [1:0] MODE_SHAKE256 = 2'b01;

    localparam logic [4:0] RATE_WORDS_128 = 5'd21;
    localparam logic [4:0] RATE_WORDS_256 = 5'd17;

    localparam logic [7:0] PAD_DOMAIN = 8'h1F;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        HANDOFF  = 2'd1,
        PAD_ONLY = 2'd2
    } load_state_t;

    // Any encoding other than SHAKE128 is handled as SHAKE256.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_SHAKE128) ? MODE_SHAKE128 : MODE_SHAKE256;
    endfunction

    function automatic logic [4:0] rate_words(input logic [1:0] m);
        return (m == MODE_SHAKE128) ? RATE_WORDS_128 : RATE_WORDS_256;
    endfunction

endpackage

// File: rtl/load_stage_if.sv
// load_stage_if: source-side word handshake plus block handoff to the
// permutation stage.
//   slave  : the load stage (consumes words, produces blocks)
//   master : the environment (word source and permutation-side sink)
interface load_stage_if;
    import keccak_pkg::*;

    logic [w-1:0]             data_in;
    logic                     valid_in;
    logic                     last_in;
    logic [3:0]               last_bytes;
    logic [1:0]               operation_mode_in;
    logic                     ready_out;
    logic [RATE_SHAKE128-1:0] input_buffer_out;
    logic [1:0]               operation_mode_out;
    logic                     input_buffer_last;
    logic                     input_buffer_we;
    logic                     input_buffer_available_wr;

    modport slave (
        input  data_in, valid_in, last_in, last_bytes, operation_mode_in,
        input  input_buffer_available_wr,
        output ready_out, input_buffer_out, operation_mode_out,
        output input_buffer_last, input_buffer_we
    );

    modport master (
        output data_in, valid_in, last_in, last_bytes, operation_mode_in,
        output input_buffer_available_wr,
        input  ready_out, input_buffer_out, operation_mode_out,
        input  input_buffer_last, input_buffer_we
    );

endinterface

// File: rtl/load_datapath.sv
// load_datapath: rate buffer, word counter, byte masking and padding.
//   inputs : accept/first/clear/pad_only from load_fsm, message word fields
//   outputs: buffer_out (buffer with final bit OR'd in), mode_out, last_out,
//            blk_done / set_pad (decode of the word currently offered)
module load_datapath
    import keccak_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     accept,
    input  logic                     first,
    input  logic                     clear,
    input  logic                     pad_only,
    input  logic [w-1:0]             data_in,
    input  logic                     last_in,
    input  logic [3:0]               last_bytes,
    input  logic [1:0]               mode_in,
    output logic [RATE_SHAKE128-1:0] buffer_out,
    output logic [1:0]               mode_out,
    output logic                     last_out,
    output logic                     blk_done,
    output logic                     set_pad
);

    localparam logic [RATE_SHAKE128-1:0] FINAL_128 =
        {PAD_FINAL, {(RATE_SHAKE128-8){1'b0}}};
    localparam logic [RATE_SHAKE128-1:0] FINAL_256 =
        {{(RATE_SHAKE128-RATE_SHAKE256){1'b0}}, PAD_FINAL, {(RATE_SHAKE256-8){1'b0}}};

    logic [RATE_SHAKE128-1:0] buf_q;
    logic [4:0]               word_cnt;
    logic [1:0]               eff_mode;
    logic [4:0]               rw;
    int                       k_int;
    logic                     full_last;
    logic                     word_fills;
    logic [w-1:0]             word_val;
    logic [10:0]              base_cur;
    logic [10:0]              base_nxt;

    always_comb begin
        // The first word of a message must already use its own mode's rate.
        eff_mode   = first ? norm_mode(mode_in) : mode_out;
        rw         = rate_words(eff_mode);
        k_int      = (last_bytes > 4'd8) ? 8 : int'(last_bytes);
        full_last  = last_in && (k_int == 8);
        word_fills = (word_cnt == rw - 5'd1);
        blk_done   = accept && (last_in || word_fills);
        set_pad    = accept && full_last && word_fills;
        base_cur   = {word_cnt, 6'd0};
        base_nxt   = {word_cnt + 5'd1, 6'd0};
        word_val   = data_in;
        if (last_in && !full_last) begin
            for (int j = 0; j < 8; j++) begin
                if (j == k_int) begin
                    word_val[8*j +: 8] = PAD_DOMAIN;
                end else if (j > k_int) begin
                    word_val[8*j +: 8] = 8'h00;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q    <= '0;
            word_cnt <= '0;
            mode_out <= MODE_SHAKE128;
            last_out <= 1'b0;
        end else if (clear) begin
            buf_q    <= '0;
            word_cnt <= '0;
            last_out <= 1'b0;
        end else if (pad_only) begin
            buf_q[7:0] <= PAD_DOMAIN;
            last_out   <= 1'b1;
        end else if (accept) begin
            buf_q[base_cur +: w] <= word_val;
            // Full final word with room left: padding starts the next word.
            if (full_last && !word_fills) begin
                buf_q[base_nxt +: 8] <= PAD_DOMAIN;
            end
            word_cnt <= word_cnt + 5'd1;
            if (first) begin
                mode_out <= eff_mode;
            end
            last_out <= last_in && !(full_last && word_fills);
        end
    end

    always_comb begin
        buffer_out = buf_q;
        if (last_out) begin
            buffer_out = buf_q | ((mode_out == MODE_SHAKE128) ? FINAL_128 : FINAL_256);
        end
    end

endmodule

// File: rtl/load_fsm.sv
// load_fsm: sequencing for the absorb input stage.
//   inputs : valid_in, avail (downstream can take a block), blk_done /
//            set_pad (decoded by the datapath for the word being accepted),
//            last_blk (the block held is the final one of its message)
//   outputs: ready_out, we (handoff strobe), accept, first (next accepted
//            word starts a message), pad_only (pad-only block is being built)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD     | accepting words into the buffer
// HANDOFF  | block complete, waiting for downstream, strobe when available
// PAD_ONLY | build a block holding only padding (message ended on a rate
//          | boundary with a full final word)
module load_fsm
    import keccak_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    input  logic avail,
    input  logic blk_done,
    input  logic set_pad,
    input  logic last_blk,
    output logic ready_out,
    output logic we,
    output logic accept,
    output logic first,
    output logic pad_only
);

    load_state_t state_q, state_d;
    logic        in_msg_q, in_msg_d;
    logic        pad_pending_q, pad_pending_d;

    assign ready_out = (state_q == LOAD) && !rst;
    assign accept    = valid_in && ready_out;
    assign we        = (state_q == HANDOFF) && avail && !rst;
    assign first     = !in_msg_q;
    assign pad_only  = (state_q == PAD_ONLY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            in_msg_q      <= 1'b0;
            pad_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_msg_q      <= in_msg_d;
            pad_pending_q <= pad_pending_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        in_msg_d      = in_msg_q;
        pad_pending_d = pad_pending_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    in_msg_d = 1'b1;
                end
                if (blk_done) begin
                    state_d       = HANDOFF;
                    pad_pending_d = set_pad;
                end
            end
            HANDOFF: begin
                if (avail) begin
                    if (pad_pending_q) begin
                        state_d = PAD_ONLY;
                    end else begin
                        state_d = LOAD;
                        if (last_blk) begin
                            in_msg_d = 1'b0;
                        end
                    end
                end
            end
            PAD_ONLY: begin
                state_d       = HANDOFF;
                pad_pending_d = 1'b0;
            end
            default: state_d = LOAD;
        endcase
    end

endmodule

// File: rtl/load_stage.sv
// load_stage: SHAKE absorb input stage. Packs w-bit words into a rate block,
// applies SHAKE padding and hands blocks downstream with a one-cycle strobe.
//   clk, rst : clock, synchronous active-high reset
//   bus      : load_stage_if.slave (word handshake and block handoff)
module load_stage
    import keccak_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    load_stage_if.slave  bus
);

    logic accept;
    logic first;
    logic clear;
    logic pad_only;
    logic blk_done;
    logic set_pad;

    assign bus.input_buffer_we = clear;

    load_fsm u_fsm (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (bus.valid_in),
        .avail     (bus.input_buffer_available_wr),
        .blk_done  (blk_done),
        .set_pad   (set_pad),
        .last_blk  (bus.input_buffer_last),
        .ready_out (bus.ready_out),
        .we        (clear),
        .accept    (accept),
        .first     (first),
        .pad_only  (pad_only)
    );

    load_datapath u_dp (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept),
        .first      (first),
        .clear      (clear),
        .pad_only   (pad_only),
        .data_in    (bus.data_in),
        .last_in    (bus.last_in),
        .last_bytes (bus.last_bytes),
        .mode_in    (bus.operation_mode_in),
        .buffer_out (bus.input_buffer_out),
        .mode_out   (bus.operation_mode_out),
        .last_out   (bus.input_buffer_last),
        .blk_done   (blk_done),
        .set_pad    (set_pad)
    );

endmodule

// File: tb/tb_load_stage.sv
module tb_load_stage;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    load_stage_if bus();

    load_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;

    logic [RATE_SHAKE128-1:0] cap_buf  [8];
    logic                     cap_last [8];
    logic [1:0]               cap_mode [8];
    logic [RATE_SHAKE128-1:0] exp_buf;

    // Strobe recorder, sampled mid-low-phase.
    always @(negedge clk) begin
        #2;
        if (bus.input_buffer_we === 1'b1) begin
            cap_buf[strobe_cnt % 8]  = bus.input_buffer_out;
            cap_last[strobe_cnt % 8] = bus.input_buffer_last;
            cap_mode[strobe_cnt % 8] = bus.operation_mode_out;
            strobe_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired time=%0t required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pat(input int i);
        return 64'h1111_0000_2222_0000 + 64'(i) * 64'h0000_0100_0000_0001;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] lb,
                             input logic [1:0] m);
        int n = 0;
        @(negedge clk);
        bus.data_in = d;
        bus.last_in = l;
        bus.last_bytes = lb;
        bus.operation_mode_in = m;
        bus.valid_in = 1'b1;
        while (bus.ready_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_word_timeout ready_out=%b required 1", bus.ready_out);
        end
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_strobes(input int target, output bit ok);
        int n = 0;
        while (strobe_cnt < target && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        ok = (strobe_cnt >= target);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in = '0;
        bus.last_in = 1'b0;
        bus.last_bytes = '0;
        bus.operation_mode_in = '0;
        bus.input_buffer_available_wr = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", bus.ready_out); end
        checks++; if (bus.input_buffer_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", bus.input_buffer_we); end
        checks++; if (bus.input_buffer_last !== 1'b0) begin errors++; $display("FAIL rst_last got=%b exp=0", bus.input_buffer_last); end
        checks++; if (bus.operation_mode_out !== 2'b00) begin errors++; $display("FAIL rst_mode got=%b exp=00", bus.operation_mode_out); end
        checks++; if (bus.input_buffer_out !== '0) begin errors++; $display("FAIL rst_buf got=%h exp=0", bus.input_buffer_out); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b exp=1", bus.ready_out); end
    endtask

    task automatic check_block(input string name, input int idx, input logic exp_last,
                               input logic [1:0] exp_mode);
        checks++; if (cap_buf[idx % 8] !== exp_buf) begin errors++; $display("FAIL %s_buf got=%h exp=%h", name, cap_buf[idx % 8], exp_buf); end
        checks++; if (cap_last[idx % 8] !== exp_last) begin errors++; $display("FAIL %s_last got=%b exp=%b", name, cap_last[idx % 8], exp_last); end
        checks++; if (cap_mode[idx % 8] !== exp_mode) begin errors++; $display("FAIL %s_mode got=%b exp=%b", name, cap_mode[idx % 8], exp_mode); end
    endtask

    task automatic settle_and_count(input string name, input int target);
        bit ok;
        wait_strobes(target, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_strobe_timeout got=%0d exp=%0d", name, strobe_cnt, target); end
        repeat (3) @(negedge clk);
        #3;
        checks++; if (strobe_cnt !== target) begin errors++; $display("FAIL %s_strobe_count got=%0d exp=%0d", name, strobe_cnt, target); end
    endtask

    task automatic test_shake128_abc();
        int base = strobe_cnt;
        send_word(64'h0000_0000_0063_6261, 1'b1, 4'd3, MODE_SHAKE128);
        settle_and_count("abc", base + 1);
        exp_buf = '0;
        exp_buf[63:0] = 64'h0000_0000_1F63_6261;
        exp_buf[1343:1336] = 8'h80;
        check_block("abc", base, 1'b1, 2'b00);
    endtask

    task automatic test_shake256_empty();
        int base = strobe_cnt;
        send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b1, 4'd0, MODE_SHAKE256);
        settle_and_count("empty", base + 1);
        exp_buf = '0;
        exp_buf[7:0] = 8'h1F;
        exp_buf[1087:1080] = 8'h80;
        check_block("empty", base, 1'b1, 2'b01);
    endtask

    task automatic test_shake256_full_block();
        int base = strobe_cnt;
        // Mode field on later words must be ignored.
        for (int i = 0; i < 17; i++) begin
            send_word(pat(i), (i == 16), (i == 16) ? 4'd8 : 4'd0,
                      (i == 0) ? MODE_SHAKE256 : MODE_SHAKE128);
        end
        settle_and_count("full256", base + 2);
        exp_buf = '0;
        for (int i = 0; i < 17; i++) exp_buf[64*i +: 64] = pat(i);
        check_block("full256_blk0", base, 1'b0, 2'b01);
        exp_buf = '0;
        exp_buf[7:0] = 8'h1F;
        exp_buf[1087:1080] = 8'h80;
        check_block("full256_blk1", base + 1, 1'b1, 2'b01);
    endtask

    task automatic test_shake128_lb7();
        int base = strobe_cnt;
        for (int i = 0; i < 20; i++) begin
            send_word(pat(i + 100), 1'b0, 4'd0, MODE_SHAKE128);
        end
        send_word(64'hFFEE_DDCC_BBAA_9988, 1'b1, 4'd7, MODE_SHAKE128);
        settle_and_count("lb7", base + 1);
        exp_buf = '0;
        for (int i = 0; i < 20; i++) exp_buf[64*i +: 64] = pat(i + 100);
        exp_buf[1343:1280] = 64'h9FEE_DDCC_BBAA_9988;
        check_block("lb7", base, 1'b1, 2'b00);
    endtask

    task automatic test_full_last_midblock();
        int base = strobe_cnt;
        send_word(64'h0706_0504_0302_0100, 1'b0, 4'd0, MODE_SHAKE128);
        send_word(64'h0F0E_0D0C_0B0A_0908, 1'b1, 4'd12, MODE_SHAKE128);
        settle_and_count("mid8", base + 1);
        exp_buf = '0;
        exp_buf[63:0] = 64'h0706_0504_0302_0100;
        exp_buf[127:64] = 64'h0F0E_0D0C_0B0A_0908;
        exp_buf[135:128] = 8'h1F;
        exp_buf[1343:1336] = 8'h80;
        check_block("mid8", base, 1'b1, 2'b00);
    endtask

    task automatic test_stall();
        int base = strobe_cnt;
        @(negedge clk);
        bus.input_buffer_available_wr = 1'b0;
        send_word(64'h0000_0000_0000_BBAA, 1'b1, 4'd2, MODE_SHAKE256);
        exp_buf = '0;
        exp_buf[23:0] = 24'h1F_BBAA;
        exp_buf[1087:1080] = 8'h80;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #3;
            checks++; if (bus.input_buffer_we !== 1'b0) begin errors++; $display("FAIL stall_we cyc=%0d got=%b exp=0", i, bus.input_buffer_we); end
            checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL stall_ready cyc=%0d got=%b exp=0", i, bus.ready_out); end
            checks++; if (bus.input_buffer_out !== exp_buf) begin errors++; $display("FAIL stall_buf cyc=%0d got=%h exp=%h", i, bus.input_buffer_out, exp_buf); end
        end
        @(negedge clk);
        bus.input_buffer_available_wr = 1'b1;
        #1;
        checks++; if (bus.input_buffer_we !== 1'b1) begin errors++; $display("FAIL stall_release_we got=%b exp=1", bus.input_buffer_we); end
        checks++; if (bus.input_buffer_last !== 1'b1) begin errors++; $display("FAIL stall_release_last got=%b exp=1", bus.input_buffer_last); end
        checks++; if (bus.operation_mode_out !== 2'b01) begin errors++; $display("FAIL stall_release_mode got=%b exp=01", bus.operation_mode_out); end
        @(negedge clk);
        #3;
        checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL stall_after_ready got=%b exp=1", bus.ready_out); end
        checks++; if (bus.input_buffer_we !== 1'b0) begin errors++; $display("FAIL stall_after_we got=%b exp=0", bus.input_buffer_we); end
        checks++; if (strobe_cnt !== base + 1) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", strobe_cnt, base + 1); end
    endtask

    task automatic test_reset_mid_message();
        int base = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            send_word(pat(i + 50), 1'b0, 4'd0, MODE_SHAKE128);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL midrst_ready got=%b exp=0", bus.ready_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #3;
        checks++; if (strobe_cnt !== base) begin errors++; $display("FAIL midrst_no_strobe got=%0d exp=%0d", strobe_cnt, base); end
        send_word(64'h0000_0000_0000_0077, 1'b1, 4'd1, MODE_SHAKE256);
        settle_and_count("midrst", base + 1);
        exp_buf = '0;
        exp_buf[15:0] = 16'h1F77;
        exp_buf[1087:1080] = 8'h80;
        check_block("midrst", base, 1'b1, 2'b01);
    endtask

    initial begin
        test_reset();
        test_shake128_abc();
        test_shake256_empty();
        test_shake256_full_block();
        test_shake128_lb7();
        test_full_last_midblock();
        test_stall();
        test_reset_mid_message();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
